// File: rtl/ascon_arbiter.sv
// ascon_arbiter
//   Shares one ascon_top encryption core between NB_REQ requesters.
//   The arbiter grants round-robin, launches the core with the winner's
//   key and nonce, and routes the winner's data into the core. It routes
//   cipher blocks and the final tag back to the requesters.
//
// Optional feature macro: ASCON_ARB_LOCK_EN
//   When defined, a requester holding lock_i with req_i still high at the
//   end of its op is re-granted immediately, with no IDLE gap.
//   When undefined, lock_i is ignored and arbitration is strict round-robin.
//
// Ports
//   clock_i, resetb_i     clock, async active-low reset
//   req_i / lock_i        per-requester request / grant lock
//   key_i / nonce_i       per-requester 128-bit key / nonce, packed [NB_REQ-1:0][127:0]
//   data_i / data_valid_i per-requester 64-bit data block and strobe
//   gnt_o                 one-hot grant, 0 when idle
//   cipher_valid_o        cipher strobe, raised only for the granted requester
//   cipher_o              cipher block, broadcast to all requesters
//   tag_o                 tag of the last completed op, broadcast
//   done_o                1-cycle completion pulse to the owner
//   core_*_o              drive the ascon_top inputs (key/nonce registered)
//   core_*_i              come from the ascon_top outputs
module ascon_arbiter #(
  parameter int unsigned NB_REQ = 2
) (
  input  logic                     clock_i,
  input  logic                     resetb_i,
  input  logic [NB_REQ-1:0]        req_i,
  input  logic [NB_REQ-1:0]        lock_i,
  input  logic [NB_REQ-1:0][127:0] key_i,
  input  logic [NB_REQ-1:0][127:0] nonce_i,
  input  logic [NB_REQ-1:0][63:0]  data_i,
  input  logic [NB_REQ-1:0]        data_valid_i,
  output logic [NB_REQ-1:0]        gnt_o,
  output logic [NB_REQ-1:0]        cipher_valid_o,
  output logic [63:0]              cipher_o,
  output logic [127:0]             tag_o,
  output logic [NB_REQ-1:0]        done_o,
  output logic                     core_start_o,
  output logic [127:0]             core_key_o,
  output logic [127:0]             core_nonce_o,
  output logic [63:0]              core_data_o,
  output logic                     core_data_valid_o,
  input  logic [63:0]              core_cipher_i,
  input  logic                     core_cipher_valid_i,
  input  logic [127:0]             core_tag_i,
  input  logic                     core_end_i
);

  localparam int unsigned IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [IW-1:0]   rr_next;
  logic            busy;

  function automatic logic [NB_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NB_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: the first set request at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NB_REQ;
      if (!pick_vld && req_i[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign rr_next = (32'(owner) == NB_REQ - 1) ? '0 : owner + IW'(1);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      gnt_o        <= '0;
      done_o       <= '0;
      core_start_o <= 1'b0;
      core_key_o   <= '0;
      core_nonce_o <= '0;
      tag_o        <= '0;
    end else begin
      core_start_o <= 1'b0;
      done_o       <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            owner        <= pick;
            gnt_o        <= onehot(pick);
            core_key_o   <= key_i[pick];
            core_nonce_o <= nonce_i[pick];
            core_start_o <= 1'b1;
            state        <= S_START;
          end
        end
        S_START: state <= S_BUSY;
        S_BUSY: begin
          if (core_end_i) begin
            tag_o  <= core_tag_i;
            done_o <= gnt_o;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef ASCON_ARB_LOCK_EN
          // A locked owner keeps the grant and the pointer, and restarts
          // the core with freshly sampled key and nonce.
          if (lock_i[owner] && req_i[owner]) begin
            core_key_o   <= key_i[owner];
            core_nonce_o <= nonce_i[owner];
            core_start_o <= 1'b1;
            state        <= S_START;
          end else begin
            rr_ptr <= rr_next;
            gnt_o  <= '0;
            state  <= S_IDLE;
          end
`else
          rr_ptr <= rr_next;
          gnt_o  <= '0;
          state  <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef ASCON_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock_i;
`endif

  // The data and cipher paths are open only while the core is running.
  // Strobes seen in other states are dropped.
  assign busy              = (state == S_BUSY);
  assign core_data_o       = data_i[owner];
  assign core_data_valid_o = busy & data_valid_i[owner];
  assign cipher_valid_o    = (busy && core_cipher_valid_i) ? gnt_o : '0;
  assign cipher_o          = core_cipher_i;

endmodule

// File: tb/tb_ascon_arbiter.sv
module tb_ascon_arbiter;

  localparam int unsigned NB = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NB-1:0]        req_i;
  logic [NB-1:0]        lock_i;
  logic [NB-1:0][127:0] key_i;
  logic [NB-1:0][127:0] nonce_i;
  logic [NB-1:0][63:0]  data_i;
  logic [NB-1:0]        data_valid_i;
  logic [NB-1:0]        gnt_o;
  logic [NB-1:0]        cipher_valid_o;
  logic [63:0]          cipher_o;
  logic [127:0]         tag_o;
  logic [NB-1:0]        done_o;
  logic                 core_start_o;
  logic [127:0]         core_key_o;
  logic [127:0]         core_nonce_o;
  logic [63:0]          core_data_o;
  logic                 core_data_valid_o;
  logic [63:0]          core_cipher_i;
  logic                 core_cipher_valid_i;
  logic [127:0]         core_tag_i;
  logic                 core_end_i;

  ascon_arbiter #(.NB_REQ(NB)) dut (
    .clock_i             (clk),
    .resetb_i            (rst_n),
    .req_i               (req_i),
    .lock_i              (lock_i),
    .key_i               (key_i),
    .nonce_i             (nonce_i),
    .data_i              (data_i),
    .data_valid_i        (data_valid_i),
    .gnt_o               (gnt_o),
    .cipher_valid_o      (cipher_valid_o),
    .cipher_o            (cipher_o),
    .tag_o               (tag_o),
    .done_o              (done_o),
    .core_start_o        (core_start_o),
    .core_key_o          (core_key_o),
    .core_nonce_o        (core_nonce_o),
    .core_data_o         (core_data_o),
    .core_data_valid_o   (core_data_valid_o),
    .core_cipher_i       (core_cipher_i),
    .core_cipher_valid_i (core_cipher_valid_i),
    .core_tag_i          (core_tag_i),
    .core_end_i          (core_end_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_cmp;
  int unsigned  n_err;
  int unsigned  m_rr;   // reference round-robin pointer
  logic [127:0] m_tag;  // reference tag of the last completed op

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] oh(input int unsigned i);
    return NB'(1) << i;
  endfunction

  // Reference arbitration: scan requesters starting at the pointer, wrapping.
  function automatic int unsigned model_pick(input logic [NB-1:0] req);
    for (int unsigned i = 0; i < NB; i++)
      if (req[(m_rr + i) % NB]) return (m_rr + i) % NB;
    return 0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_keys();
    for (int unsigned c = 0; c < NB; c++) begin
      key_i[c]   = rnd128();
      nonce_i[c] = rnd128();
    end
  endtask

  // Runs one complete op. The caller leaves the DUT idle, 1 time unit after an edge.
  task automatic run_op(input logic [NB-1:0] mask, input bit rand_keys);
    int unsigned  w;
    int unsigned  nb;
    logic [127:0] k;
    logic [127:0] n;
    logic [127:0] t;
    w = model_pick(mask);
    if (rand_keys) scramble_keys();
`ifndef ASCON_ARB_LOCK_EN
    lock_i = NB'($urandom());
`endif
    req_i = mask;
    k = key_i[w];
    n = nonce_i[w];
    tick();
    check("gnt", 128'(gnt_o), 128'(oh(w)));
    check("start_hi", 128'(core_start_o), 128'(1));
    check("key_reg", core_key_o, k);
    check("nonce_reg", core_nonce_o, n);
    // Key and nonce changes after the grant, and a dropped request, must be ignored.
    scramble_keys();
    if ($urandom_range(1, 0) == 1) req_i[w] = 1'b0;
    tick();
    check("start_lo", 128'(core_start_o), 128'(0));
    nb = $urandom_range(4, 1);
    for (int unsigned b = 0; b < nb; b++) begin
      for (int unsigned c = 0; c < NB; c++) data_i[c] = {$urandom(), $urandom()};
      data_valid_i        = NB'($urandom());
      core_cipher_valid_i = 1'($urandom());
      core_cipher_i       = {$urandom(), $urandom()};
      #1;
      check("data_valid", 128'(core_data_valid_o), 128'(data_valid_i[w]));
      check("data", 128'(core_data_o), 128'(data_i[w]));
      check("cipher_valid", 128'(cipher_valid_o), core_cipher_valid_i ? 128'(oh(w)) : 128'(0));
      check("cipher", 128'(cipher_o), 128'(core_cipher_i));
      tick();
    end
    data_valid_i        = '0;
    core_cipher_valid_i = 1'b0;
    t           = rnd128();
    core_tag_i  = t;
    core_end_i  = 1'b1;
    tick();
    m_tag = t;
    check("done", 128'(done_o), 128'(oh(w)));
    check("tag", tag_o, m_tag);
    check("key_hold", core_key_o, k);
    // Core strobes outside the running phase must be ignored.
    core_tag_i          = '1;
    core_cipher_valid_i = 1'b1;
    #1;
    check("cipher_valid_done", 128'(cipher_valid_o), 128'(0));
    tick();
    core_end_i          = 1'b0;
    core_cipher_valid_i = 1'b0;
    req_i               = '0;
    check("gnt_idle", 128'(gnt_o), 128'(0));
    check("done_once", 128'(done_o), 128'(0));
    check("tag_idle", tag_o, m_tag);
    m_rr = (w + 1) % NB;
  endtask

  task automatic idle_end();
    req_i      = '0;
    core_tag_i = '1;
    core_end_i = 1'b1;
    tick();
    core_end_i = 1'b0;
    tick();
    check("idle_end_tag", tag_o, m_tag);
    check("idle_end_done", 128'(done_o), 128'(0));
    check("idle_end_gnt", 128'(gnt_o), 128'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_rr  = 0;
    m_tag = '0;
    rst_n = 1'b0;
    req_i = '0;
    lock_i = '0;
    key_i = '0;
    nonce_i = '0;
    data_i = '0;
    data_valid_i = '0;
    core_cipher_i = '0;
    core_cipher_valid_i = 1'b0;
    core_tag_i = '0;
    core_end_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 128'(gnt_o), 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    check("rst_tag", tag_o, 128'(0));
    check("rst_key", core_key_o, 128'(0));
    check("rst_nonce", core_nonce_o, 128'(0));
    check("rst_start", 128'(core_start_o), 128'(0));
    check("rst_cv", 128'(cipher_valid_o), 128'(0));
    rst_n = 1'b1;
    tick();

    // Directed first op: requester 0 alone, with a counting key and nonce.
    key_i[0]   = 128'h000102030405060708090A0B0C0D0E0F;
    nonce_i[0] = 128'h101112131415161718191A1B1C1D1E1F;
    run_op(NB'(1), 1'b0);

    // Two requesters held over four ops must alternate.
    repeat (4) run_op(NB'(3), 1'b1);

    idle_end();

    for (int unsigned r = 0; r < 40; r++) begin
      run_op(NB'($urandom_range((1 << NB) - 1, 1)), 1'b1);
      if ($urandom_range(3, 0) == 0) idle_end();
    end

    // Asynchronous reset while the core is running.
    req_i = NB'(2);
    tick();
    tick();
    data_valid_i = '1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 128'(gnt_o), 128'(0));
    check("arst_tag", tag_o, 128'(0));
    check("arst_key", core_key_o, 128'(0));
    check("arst_data_valid", 128'(core_data_valid_o), 128'(0));
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    req_i        = '0;
    data_valid_i = '0;
    m_rr         = 0;
    m_tag        = '0;
    tick();
    run_op(NB'(7), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
